// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous-read memory between two requesters.
// Each requester raises req and holds we/addr/wdata stable until its ack.
// The arbiter grants round-robin, drives one memory strobe for exactly one
// cycle per access, and answers with a one-cycle ack (plus rdata for reads).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0/we0/addr0/wdata0    requester 0 request side
//   ack0/rdata0              requester 0 completion side
//   req1/we1/addr1/wdata1    requester 1 request side
//   ack1/rdata1              requester 1 completion side
//   busy                     high whenever the sequencer is not idle
//   mem_write/mem_read       one-cycle memory strobes
//   mem_address              memory address
//   mem_write_data           memory write data
//   mem_read_data            memory read data, valid the cycle after mem_read
//
// Every output comes straight from a flop.

module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        ACK
    } state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  we_q, we_d;
    logic                  last_q, last_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  busy_q, busy_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_read_q, mem_read_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
    logic                  winner;

    // Next-state logic for the whole sequencer.
    // Strobes and acks are decided one state early so that, once registered,
    // they appear in the cycle they belong to: the strobe is set on the
    // IDLE->ISSUE edge, a write's ack on the ISSUE->ACK edge, and a read's
    // ack together with its data on the CAPTURE->ACK edge.
    // When both requesters are waiting, the one that was not served last
    // wins; last_q resets to 1 so requester 0 wins the very first tie.
    // mem_address and mem_write_data simply hold between accesses, and
    // mem_address_q doubles as the latched address of the granted request.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        we_d             = we_q;
        last_d           = last_q;
        ack0_d           = 1'b0;
        ack1_d           = 1'b0;
        rdata0_d         = rdata0_q;
        rdata1_d         = rdata1_q;
        mem_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        winner           = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner  = (req0 && req1) ? ~last_q : req1;
                    grant_d = winner;
                    last_d  = winner;
                    state_d = ISSUE;
                    if (winner) begin
                        we_d          = we1;
                        mem_address_d = addr1;
                        if (we1) begin
                            mem_write_d      = 1'b1;
                            mem_write_data_d = wdata1;
                        end else begin
                            mem_read_d = 1'b1;
                        end
                    end else begin
                        we_d          = we0;
                        mem_address_d = addr0;
                        if (we0) begin
                            mem_write_d      = 1'b1;
                            mem_write_data_d = wdata0;
                        end else begin
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end

            ISSUE: begin
                if (we_q) begin
                    state_d = ACK;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                end else begin
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                state_d = ACK;
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
                if (grant_q) begin
                    rdata1_d = mem_read_data;
                end else begin
                    rdata0_d = mem_read_data;
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    // Reset drops any in-flight access without an ack; a write that was
    // already strobed has reached memory and stays there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            grant_q          <= 1'b0;
            we_q             <= 1'b0;
            last_q           <= 1'b1;
            ack0_q           <= 1'b0;
            ack1_q           <= 1'b0;
            rdata0_q         <= '0;
            rdata1_q         <= '0;
            busy_q           <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            we_q             <= we_d;
            last_q           <= last_d;
            ack0_q           <= ack0_d;
            ack1_q           <= ack1_d;
            rdata0_q         <= rdata0_d;
            rdata1_q         <= rdata1_d;
            busy_q           <= busy_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign busy           = busy_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer that shares the single-port `memory` block (one write/read port, synchronous read) between requester 0 (e.g. instruction fetch) and requester 1 (e.g. load/store).
- Accepts `req`/`ack` transactions, arbitrates round-robin, drives the memory strobes for exactly one cycle per access, and returns read data with a one-cycle `ack` pulse.
- Sits between the VeriRISC core's access units and `memory`.

Parameters:
- ADDR_WIDTH, 8, width of address on both sides.
- DATA_WIDTH, 32, data word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request; held until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read; stable while req0.
- addr0  in  ADDR_WIDTH  requester 0 address; stable while req0.
- wdata0  in  DATA_WIDTH  requester 0 write data; stable while req0.
- ack0  out  1  one-cycle completion pulse to requester 0.
- rdata0  out  DATA_WIDTH  read result for requester 0; valid when ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as above, for requester 1.
- busy  out  1  high whenever the FSM is not IDLE.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_write_data  out  DATA_WIDTH  memory write data.
- mem_read_data  in  DATA_WIDTH  memory read data; registered inside memory, valid the cycle after mem_read=1.

Behaviour:
- All outputs are registered.
- Reset values: ack0/1=0, rdata0/1=0, busy=0, mem_write=0, mem_read=0, mem_address=0, mem_write_data=0, FSM=IDLE, last-grant pointer=1 (requester 0 wins first tie).
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that requester wins.
  - Both req: the requester not equal to the last-grant pointer wins.
  - On the edge: latch the winner's id, we, addr and wdata; update the pointer to the winner; go to ISSUE.
- ISSUE (one cycle):
  - mem_address = latched addr.
  - write: mem_write=1, mem_write_data = latched wdata; next state ACK.
  - read: mem_read=1; next state CAPTURE.
- CAPTURE (reads only):
  - All strobes 0; mem_address holds.
  - Sample mem_read_data into rdata of the winner; next state ACK.
- ACK (one cycle): ack of the winner = 1, the other ack = 0; next state IDLE.
- Latency, counting the cycle req is first seen in IDLE as cycle 0:
  - write: mem_write in cycle 1, ack in cycle 2.
  - read: mem_read in cycle 1, data captured end of cycle 2, ack + rdata in cycle 3.
- rdata of each port holds its last value until that port's next read completes; writes do not alter rdata.
- mem_write and mem_read are never high together, never high outside ISSUE, and each is high exactly one cycle per transaction.
- The arbiter samples requests only in IDLE. Requests arriving while busy wait; the requester keeps req asserted.
- A req still high in the cycle after its ack is treated as a new request.
- Address and data are passed through unmodified; no wrap or width arithmetic is applied.
- Ports are served strictly one transaction at a time. A write from one port is visible to a later-granted read from the other.
- Reset mid-transaction:
  - The FSM returns to IDLE and all strobes, acks and rdata clear next cycle.
  - The in-flight access is dropped with no ack. A write already strobed in ISSUE remains in memory.

Test Plan:
- Write, then read, same port: rst 2 cycles; req0 we0=1 addr0=8'h01 wdata0=32'hA5A5A5A5 → mem_write=1 exactly one cycle with mem_address=8'h01, ack0 2 cycles after req; then req0 we0=0 addr0=8'h01 → ack0 3 cycles after req, rdata0=32'hA5A5A5A5.
- Round-robin alternation: req0 and req1 both reads held continuously, 4 transactions → ack order 0,1,0,1; ack0 and ack1 never high in the same cycle; busy drops to 0 one cycle between transactions.
- Cross-port coherence: port 1 writes 32'h5A5A5A5A to 8'h01 while port 0 read of 8'h01 is pending → port 1 granted first (pointer reset to 1 means port 0 wins ties only when both present; here port 1 requests first) → rdata0=32'h5A5A5A5A.
- Single requester repeat: req1 only, 3 writes to 8'h10/8'h11/8'h12 → each granted despite pointer; reading them back returns the written values.
- Reset mid-read: assert rst during CAPTURE → next cycle ack0=0, rdata0=0, busy=0, mem_read=0; no ack for the dropped read; the next req0 read completes normally.
- Strobe invariant: over a random 200-transaction mixed run, check (mem_write & mem_read) never 1; count of strobes equals count of acks; each rdata matches a reference memory model.
